periph_bridge: RTL and testbench
================================

// Module: periph_bridge
// PURPOSE
//  Request bridge between the CPU load/store stage and the memory-mapped peripheral banks
//  (timer and siblings). Takes one CPU request per valid/ready handshake and decodes the
//  address against a table of peripheral windows. Drives the shared peripheral request bus
//  with a one-cycle write strobe gated to the selected slot, then registers that slot's
//  response and holds it until the CPU accepts it.
// PARAMETERS
//  NUM_PERIPH   2                       number of peripheral slots
//  PERIPH_BASE  {ADDR_W'd16, ADDR_W'd0}  packed NUM_PERIPH*ADDR_W; slot i base = [i*ADDR_W +: ADDR_W]
//  PERIPH_SIZE  {ADDR_W'd4,  ADDR_W'd5}  packed; slot i window = [base, base+size)
//  WAIT_CYCLES  0                       extra settle cycles before sampling the response (0..15)
//  ERR_CODE     1                       MEM_CODE_W code returned for unmapped addresses
// PORTS
//  clk               in   1                       clock; all state updates on rising edge
//  aresetn           in   1                       asynchronous active-low reset
//  i_cpu_req_valid   in   1                       CPU request valid
//  o_cpu_req_ready   out  1                       bridge can accept a request
//  i_cpu_req_addr    in   ADDR_W                  request address
//  i_cpu_req_wr_data in   WORD_W                  write data
//  i_cpu_req_wr_en   in   1                       1 = write, 0 = read
//  i_cpu_req_count   in   MEM_COUNT_W             access size, passed through unchanged
//  o_cpu_res_valid   out  1                       response valid
//  i_cpu_res_ready   in   1                       CPU accepts the response
//  o_cpu_res_rd_data out  WORD_W                  response read data
//  o_cpu_res_code    out  MEM_CODE_W              response code
//  o_per_req_addr    out  ADDR_W                  shared peripheral address
//  o_per_req_wr_data out  WORD_W                  shared peripheral write data
//  o_per_req_wr_en   out  NUM_PERIPH              per-slot write strobe
//  o_per_req_count   out  MEM_COUNT_W             shared access size
//  i_per_res_rd_data in   NUM_PERIPH*WORD_W       slot i read data = [i*WORD_W +: WORD_W]
//  i_per_res_code    in   NUM_PERIPH*MEM_CODE_W   slot i response code
// BEHAVIOUR
//  - FSM states: IDLE -> ISSUE -> SETTLE (only if WAIT_CYCLES>0) -> RESP -> IDLE.
//  - Reset (async, any state): state=IDLE; res_valid=0; res_rd_data=0; res_code=0.
//    All o_per_req_* = 0. Any in-flight transaction is dropped; no strobe after reset.
//  - o_cpu_req_ready = (state==IDLE) and is 1 after reset; the request is accepted when valid & ready.
//  - On accept: register addr, wr_data, wr_en, count. Decode hit[i] = addr>=base_i && addr-base_i<size_i.
//    The window check is unsigned, in ADDR_W arithmetic, with no wrap. On overlap, the lowest index
//    wins. No hit -> unmapped.
//  - ISSUE (1 cycle): o_per_req_* driven from the registers. o_per_req_wr_en[sel] = wr_en; other bits 0.
//  - Unmapped: all strobes stay 0.
//  - SETTLE: count down WAIT_CYCLES cycles. addr/data/count are held and wr_en is 0.
//  - In the last ISSUE/SETTLE cycle, the selected slot's rd_data/code are sampled into the response
//    registers. For unmapped requests the sample is rd_data=0, code=ERR_CODE.
//  - Latency: accept at cycle 0 -> o_cpu_res_valid=1 from cycle 2+WAIT_CYCLES.
//  - RESP: res_valid=1; data/code are stable while res_ready=0. On res_ready, go to IDLE; valid drops
//    the next cycle. Throughput is one transaction per 3+WAIT_CYCLES cycles with no backpressure.
//  - Outside ISSUE/SETTLE, o_per_req_addr/wr_data/count hold their last value and wr_en=0.
//  - A write strobe is exactly one cycle per accepted write, never repeated, even under response
//    backpressure.
// TESTING
//  1. Write 0x0000000F to addr 0 (slot0) -> o_per_req_wr_en=2'b01 in cycle 1 only; addr=0, data=0xF.
//     Response at cycle 2 carries slot0 code.
//  2. Read addr 17 (slot1 window 16..19), slot1 rd_data=0xDEADBEEF -> res_rd_data=0xDEADBEEF at
//     cycle 2; wr_en stays 2'b00.
//  3. Write addr 0x40 (unmapped) -> no wr_en bit ever set; response rd_data=0, code=ERR_CODE.
//     Addr 5 (slot0 end) also unmapped.
//  4. Hold res_ready=0 for 3 cycles after a read -> res_valid, data, code stable; req_ready=0;
//     a new req_valid is not accepted. Release -> IDLE the next cycle.
//  5. WAIT_CYCLES=2: read slot0; slot0 data changes in cycle 2 then settles -> response valid at
//     cycle 4 with the value present in cycle 3.
//  6. Assert aresetn=0 during ISSUE of a write -> wr_en=0 immediately, res_valid=0; after release,
//     req_ready=1 and no stale response.

Source files
------------

// File: rtl/periph_bridge.sv
// periph_bridge
//   Bridges CPU load/store requests onto the shared memory-mapped peripheral bus.
//   Each accepted request is decoded against a table of address windows. It is then
//   driven on the peripheral bus for one cycle, with the write strobe gated to the
//   selected slot. Optional settle cycles follow. The selected slot's response is then
//   registered and held until the CPU accepts it.
// Ports
//   clk, aresetn                     clock, asynchronous active-low reset
//   i_cpu_req_*/o_cpu_req_ready      CPU request channel (valid/ready)
//   o_cpu_res_*/i_cpu_res_ready      CPU response channel (valid/ready)
//   o_per_req_*                      shared peripheral request bus (per-slot write strobe)
//   i_per_res_rd_data/i_per_res_code packed per-slot responses, slot i at index i
module periph_bridge #(
  parameter int ADDR_W      = 32,
  parameter int WORD_W      = 32,
  parameter int MEM_COUNT_W = 2,
  parameter int MEM_CODE_W  = 2,
  parameter int NUM_PERIPH  = 2,
  parameter logic [NUM_PERIPH*ADDR_W-1:0] PERIPH_BASE = {ADDR_W'(16), ADDR_W'(0)},
  parameter logic [NUM_PERIPH*ADDR_W-1:0] PERIPH_SIZE = {ADDR_W'(4), ADDR_W'(5)},
  parameter int WAIT_CYCLES = 0,
  parameter logic [MEM_CODE_W-1:0] ERR_CODE = MEM_CODE_W'(1)
) (
  input  logic                         clk,
  input  logic                         aresetn,
  input  logic                         i_cpu_req_valid,
  output logic                         o_cpu_req_ready,
  input  logic [ADDR_W-1:0]            i_cpu_req_addr,
  input  logic [WORD_W-1:0]            i_cpu_req_wr_data,
  input  logic                         i_cpu_req_wr_en,
  input  logic [MEM_COUNT_W-1:0]       i_cpu_req_count,
  output logic                         o_cpu_res_valid,
  input  logic                         i_cpu_res_ready,
  output logic [WORD_W-1:0]            o_cpu_res_rd_data,
  output logic [MEM_CODE_W-1:0]        o_cpu_res_code,
  output logic [ADDR_W-1:0]            o_per_req_addr,
  output logic [WORD_W-1:0]            o_per_req_wr_data,
  output logic [NUM_PERIPH-1:0]        o_per_req_wr_en,
  output logic [MEM_COUNT_W-1:0]       o_per_req_count,
  input  logic [NUM_PERIPH*WORD_W-1:0] i_per_res_rd_data,
  input  logic [NUM_PERIPH*MEM_CODE_W-1:0] i_per_res_code
);

  localparam int SEL_W = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
  // Settle counter reload: SETTLE lasts exactly WAIT_CYCLES cycles, counting down to zero.
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t                  state_r;
  logic [ADDR_W-1:0]       per_addr_r;
  logic [WORD_W-1:0]       per_wr_data_r;
  logic [NUM_PERIPH-1:0]   per_wr_en_r;
  logic [MEM_COUNT_W-1:0]  per_count_r;
  logic [SEL_W-1:0]        sel_r;
  logic                    hit_r;
  logic [3:0]              wait_cnt_r;
  logic                    res_valid_r;
  logic [WORD_W-1:0]       res_rd_data_r;
  logic [MEM_CODE_W-1:0]   res_code_r;

  logic                    hit_s;
  logic [SEL_W-1:0]        sel_s;
  logic [NUM_PERIPH-1:0]   wr_strobe_s;
  logic [WORD_W-1:0]       rsp_data_s;
  logic [MEM_CODE_W-1:0]   rsp_code_s;

  // Address decode of the incoming request; scanning from the top lets the lowest index win.
  always_comb begin
    logic [ADDR_W-1:0] base_v;
    logic [ADDR_W-1:0] size_v;
    hit_s  = 1'b0;
    sel_s  = '0;
    base_v = '0;
    size_v = '0;
    for (int i = NUM_PERIPH - 1; i >= 0; i--) begin
      base_v = PERIPH_BASE[i*ADDR_W +: ADDR_W];
      size_v = PERIPH_SIZE[i*ADDR_W +: ADDR_W];
      // The lower-bound test first guarantees the subtraction cannot wrap.
      if ((i_cpu_req_addr >= base_v) && ((i_cpu_req_addr - base_v) < size_v)) begin
        hit_s = 1'b1;
        sel_s = SEL_W'(i);
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Write strobe for the decoded slot; an unmapped request produces no strobe.
  always_comb begin
    wr_strobe_s = '0;
    if (hit_s) begin
      wr_strobe_s[sel_s] = i_cpu_req_wr_en;
    end else begin
      wr_strobe_s = '0;
    end
  end

  // Response mux for the captured slot; unmapped requests answer with zero data and ERR_CODE.
  always_comb begin
    rsp_data_s = '0;
    rsp_code_s = ERR_CODE;
    for (int i = 0; i < NUM_PERIPH; i++) begin
      if (hit_r && (sel_r == SEL_W'(i))) begin
        rsp_data_s = i_per_res_rd_data[i*WORD_W +: WORD_W];
        rsp_code_s = i_per_res_code[i*MEM_CODE_W +: MEM_CODE_W];
      end else begin
        rsp_data_s = rsp_data_s;
      end
    end
  end

  // Transaction FSM; every bus and response output comes straight from these registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r       <= ST_IDLE;
      per_addr_r    <= '0;
      per_wr_data_r <= '0;
      per_wr_en_r   <= '0;
      per_count_r   <= '0;
      sel_r         <= '0;
      hit_r         <= 1'b0;
      wait_cnt_r    <= 4'd0;
      res_valid_r   <= 1'b0;
      res_rd_data_r <= '0;
      res_code_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_cpu_req_valid) begin
            per_addr_r    <= i_cpu_req_addr;
            per_wr_data_r <= i_cpu_req_wr_data;
            per_wr_en_r   <= wr_strobe_s;
            per_count_r   <= i_cpu_req_count;
            sel_r         <= sel_s;
            hit_r         <= hit_s;
            state_r       <= ST_ISSUE;
          end else begin
            per_wr_en_r <= '0;
          end
        end
        ST_ISSUE: begin
          // The strobe lives only in ISSUE, so it can never repeat under backpressure.
          per_wr_en_r <= '0;
          if (WAIT_CYCLES == 0) begin
            res_valid_r   <= 1'b1;
            res_rd_data_r <= rsp_data_s;
            res_code_r    <= rsp_code_s;
            state_r       <= ST_RESP;
          end else begin
            wait_cnt_r <= WAIT_LAST;
            state_r    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (wait_cnt_r == 4'd0) begin
            res_valid_r   <= 1'b1;
            res_rd_data_r <= rsp_data_s;
            res_code_r    <= rsp_code_s;
            state_r       <= ST_RESP;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          if (i_cpu_res_ready) begin
            res_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            res_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          per_wr_en_r <= '0;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_cpu_req_ready   = (state_r == ST_IDLE);
  assign o_cpu_res_valid   = res_valid_r;
  assign o_cpu_res_rd_data = res_rd_data_r;
  assign o_cpu_res_code    = res_code_r;
  assign o_per_req_addr    = per_addr_r;
  assign o_per_req_wr_data = per_wr_data_r;
  assign o_per_req_wr_en   = per_wr_en_r;
  assign o_per_req_count   = per_count_r;

endmodule

// File: tb/tb_periph_bridge.sv
// tb_periph_bridge
//   Directed bench for periph_bridge: one instance with no settle cycles and one with
//   WAIT_CYCLES=2. Expected responses are queued at issue time and compared by monitors
//   whenever a response handshake completes.
module tb_periph_bridge;

  localparam logic [1:0] ERR = 2'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid0, req_valid2;
  logic [31:0] req_addr, req_wdata;
  logic        req_wr;
  logic [1:0]  req_count;
  logic        res_ready;
  logic [63:0] per_rd;
  logic [3:0]  per_code;

  logic        d0_req_ready, d0_res_valid;
  logic [31:0] d0_res_rd, d0_per_addr, d0_per_wd;
  logic [1:0]  d0_res_code, d0_per_we, d0_per_cnt;
  logic        d2_req_ready, d2_res_valid;
  logic [31:0] d2_res_rd, d2_per_addr, d2_per_wd;
  logic [1:0]  d2_res_code, d2_per_we, d2_per_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  c;
  } rsp_t;
  rsp_t q0[$];
  rsp_t q2[$];

  always #5 clk = ~clk;

  periph_bridge #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .aresetn(rst_n),
    .i_cpu_req_valid(req_valid0), .o_cpu_req_ready(d0_req_ready),
    .i_cpu_req_addr(req_addr), .i_cpu_req_wr_data(req_wdata),
    .i_cpu_req_wr_en(req_wr), .i_cpu_req_count(req_count),
    .o_cpu_res_valid(d0_res_valid), .i_cpu_res_ready(res_ready),
    .o_cpu_res_rd_data(d0_res_rd), .o_cpu_res_code(d0_res_code),
    .o_per_req_addr(d0_per_addr), .o_per_req_wr_data(d0_per_wd),
    .o_per_req_wr_en(d0_per_we), .o_per_req_count(d0_per_cnt),
    .i_per_res_rd_data(per_rd), .i_per_res_code(per_code)
  );

  periph_bridge #(.WAIT_CYCLES(2)) dut2 (
    .clk(clk), .aresetn(rst_n),
    .i_cpu_req_valid(req_valid2), .o_cpu_req_ready(d2_req_ready),
    .i_cpu_req_addr(req_addr), .i_cpu_req_wr_data(req_wdata),
    .i_cpu_req_wr_en(req_wr), .i_cpu_req_count(req_count),
    .o_cpu_res_valid(d2_res_valid), .i_cpu_res_ready(res_ready),
    .o_cpu_res_rd_data(d2_res_rd), .o_cpu_res_code(d2_res_code),
    .o_per_req_addr(d2_per_addr), .o_per_req_wr_data(d2_per_wd),
    .o_per_req_wr_en(d2_per_we), .o_per_req_count(d2_per_cnt),
    .i_per_res_rd_data(per_rd), .i_per_res_code(per_code)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor for the zero-wait instance.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && d0_res_valid && res_ready) begin
      if (q0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp0_unexpected: got data %0h code %0h with nothing queued", d0_res_rd, d0_res_code);
      end else begin
        e = q0.pop_front();
        chk("rsp0_data", 64'(d0_res_rd), 64'(e.d));
        chk("rsp0_code", 64'(d0_res_code), 64'(e.c));
      end
    end
  end

  // Response monitor for the two-settle-cycle instance.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && d2_res_valid && res_ready) begin
      if (q2.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL rsp2_unexpected: got data %0h code %0h with nothing queued", d2_res_rd, d2_res_code);
      end else begin
        e = q2.pop_front();
        chk("rsp2_data", 64'(d2_res_rd), 64'(e.d));
        chk("rsp2_code", 64'(d2_res_code), 64'(e.c));
      end
    end
  end

  // Bounded wait for the zero-wait instance to become ready.
  task automatic wait_ready0();
    int k = 0;
    while (!d0_req_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("req_ready0_wait", 64'(d0_req_ready), 64'd1);
  endtask

  // Issue one request to dut0, queue its response, check the bus in ISSUE and latency.
  task automatic req0(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                      input logic [1:0] cnt, input logic [1:0] exp_we,
                      input logic [31:0] exp_d, input logic [1:0] exp_c);
    wait_ready0();
    req_valid0 = 1'b1;
    req_addr   = addr;
    req_wdata  = wdata;
    req_wr     = wr;
    req_count  = cnt;
    q0.push_back('{d: exp_d, c: exp_c});
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("issue_wr_en", 64'(d0_per_we), 64'(exp_we));
    chk("issue_addr", 64'(d0_per_addr), 64'(addr));
    chk("issue_wdata", 64'(d0_per_wd), 64'(wdata));
    chk("issue_count", 64'(d0_per_cnt), 64'(cnt));
    @(posedge clk); #1;
    chk("post_issue_wr_en", 64'(d0_per_we), 64'd0);
    chk("res_valid_latency", 64'(d0_res_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    req_valid0 = 1'b0;
    req_valid2 = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    req_wr     = 1'b0;
    req_count  = 2'd0;
    res_ready  = 1'b1;
    per_rd     = {32'hDEAD_BEEF, 32'h1111_0000};
    per_code   = {2'd3, 2'd2};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(d0_req_ready), 64'd1);
    chk("rst_res_valid", 64'(d0_res_valid), 64'd0);
    chk("rst_wr_en", 64'(d0_per_we), 64'd0);
    chk("rst_per_addr", 64'(d0_per_addr), 64'd0);
    chk("rst_res_data", 64'(d0_res_rd), 64'd0);
    chk("rst_res_code", 64'(d0_res_code), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mapped writes and reads, including the last address of each window.
    req0(32'd0,  32'h0000_000F, 1'b1, 2'd1, 2'b01, 32'h1111_0000, 2'd2);
    req0(32'd17, 32'h0000_0000, 1'b0, 2'd2, 2'b00, 32'hDEAD_BEEF, 2'd3);
    req0(32'd19, 32'h0000_0077, 1'b1, 2'd3, 2'b10, 32'hDEAD_BEEF, 2'd3);
    req0(32'd4,  32'h0000_0044, 1'b1, 2'd0, 2'b01, 32'h1111_0000, 2'd2);

    // Unmapped: far away, just past slot0, just past slot1.
    req0(32'h40, 32'h0000_0005, 1'b1, 2'd0, 2'b00, 32'h0, ERR);
    req0(32'd5,  32'h0000_0006, 1'b1, 2'd1, 2'b00, 32'h0, ERR);
    req0(32'd20, 32'h0000_0007, 1'b1, 2'd2, 2'b00, 32'h0, ERR);
    @(posedge clk); #1;
    chk("idle_hold_addr", 64'(d0_per_addr), 64'd20);
    chk("idle_wr_en", 64'(d0_per_we), 64'd0);

    // Response backpressure: response stays frozen and new requests are refused.
    res_ready = 1'b0;
    req0(32'd17, 32'h0, 1'b0, 2'd0, 2'b00, 32'hDEAD_BEEF, 2'd3);
    per_rd[63:32] = 32'h1234_5678;
    repeat (3) begin
      req_valid0 = 1'b1;
      req_addr   = 32'd0;
      req_wr     = 1'b1;
      @(posedge clk); #1;
      chk("bp_res_valid", 64'(d0_res_valid), 64'd1);
      chk("bp_res_data", 64'(d0_res_rd), 64'hDEAD_BEEF);
      chk("bp_res_code", 64'(d0_res_code), 64'd3);
      chk("bp_req_ready", 64'(d0_req_ready), 64'd0);
      chk("bp_wr_en", 64'(d0_per_we), 64'd0);
    end
    req_valid0 = 1'b0;
    res_ready  = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ready", 64'(d0_req_ready), 64'd1);
    chk("bp_release_valid", 64'(d0_res_valid), 64'd0);
    chk("bp_release_wr_en", 64'(d0_per_we), 64'd0);
    per_rd[63:32] = 32'hDEAD_BEEF;

    // Reset during ISSUE of a write: strobe and response vanish at once.
    wait_ready0();
    req_valid0 = 1'b1;
    req_addr   = 32'd16;
    req_wdata  = 32'h0000_00AA;
    req_wr     = 1'b1;
    @(posedge clk); #1;
    req_valid0 = 1'b0;
    chk("rst_issue_wr_en", 64'(d0_per_we), 64'b10);
    rst_n = 1'b0;
    #1;
    chk("rst_async_wr_en", 64'(d0_per_we), 64'd0);
    chk("rst_async_valid", 64'(d0_res_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_valid", 64'(d0_res_valid), 64'd0);
      chk("post_rst_wr_en", 64'(d0_per_we), 64'd0);
    end
    chk("post_rst_ready", 64'(d0_req_ready), 64'd1);
    req0(32'd1, 32'h0000_0011, 1'b1, 2'd1, 2'b01, 32'h1111_0000, 2'd2);

    // Two settle cycles: the response takes the slot data present in cycle 3.
    @(posedge clk); #1;
    per_rd[31:0] = 32'hAAAA_0001;
    chk("w2_ready", 64'(d2_req_ready), 64'd1);
    req_valid2 = 1'b1;
    req_addr   = 32'd2;
    req_wdata  = 32'h0;
    req_wr     = 1'b0;
    req_count  = 2'd3;
    q2.push_back('{d: 32'h600D_F00D, c: 2'd2});
    @(posedge clk); #1;
    req_valid2 = 1'b0;
    chk("w2_c1_wr_en", 64'(d2_per_we), 64'd0);
    chk("w2_c1_valid", 64'(d2_res_valid), 64'd0);
    @(posedge clk); #1;
    per_rd[31:0] = 32'hBAD0_BAD0;
    chk("w2_c2_valid", 64'(d2_res_valid), 64'd0);
    chk("w2_c2_addr", 64'(d2_per_addr), 64'd2);
    chk("w2_c2_count", 64'(d2_per_cnt), 64'd3);
    @(posedge clk); #1;
    per_rd[31:0] = 32'h600D_F00D;
    chk("w2_c3_valid", 64'(d2_res_valid), 64'd0);
    @(posedge clk); #1;
    chk("w2_c4_valid", 64'(d2_res_valid), 64'd1);
    per_rd[31:0] = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    chk("w2_done_ready", 64'(d2_req_ready), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", 64'(q0.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
